wb_uart: RTL and testbench
==========================

// Module: wb_uart
// PURPOSE
//  Wishbone pipelined slave (responder) implementing an 8N1 UART with a programmable baud divisor.
//  Sits on one I/O slave port of the CPU interconnect (e.g. 5000H window) and answers
//  single-word 16-bit accesses.
//  Each accepted request gets exactly one ack, on the cycle after acceptance, as the
//  interconnect's registered ack/data return path requires.
// PARAMETERS
//  DEFAULT_DIV  433  reset value of DIV; bit period = DIV+1 clk cycles (50 MHz -> 115200 Bd)
// PORTS
//  wb      if_wb.slave  -    Wishbone bus; members below (interface clock/reset are the block's)
//  wb.clk    in   1   clock; one clock, everything on posedge
//  wb.rst    in   1   reset; synchronous, active-high
//  wb.adr    in   16  byte address; only adr[2:1] decoded (register index)
//  wb.dat_i  in   16  write data
//  wb.dat_o  out  16  read data, valid while ack=1
//  wb.we     in   1   1=write, 0=read
//  wb.cyc    in   1   bus cycle active
//  wb.stb    in   1   request strobe
//  wb.ack    out  1   registered acknowledge
//  wb.stall  out  1   tied 0 (one request per cycle accepted)
//  rxd       in   1   serial input, asynchronous, idle high
//  txd       out  1   serial output, idle high
//  irq       out  1   level interrupt = rx_valid
// BEHAVIOUR
//  Reset: ack=0, dat_o=0, txd=1, irq=0, rx_valid=0, overrun=0, frame_err=0, DIV=DEFAULT_DIV,
//   TX/RX FSMs IDLE, counters 0.
//  Handshake: req = cyc&stb (stall=0 -> always accepted); ack <= req every cycle;
//   back-to-back requests give back-to-back acks; dat_o <= read data when req&~we, else 0.
//  Registers (adr[2:1]):
//   0 DATA   W: low byte starts TX if TX IDLE; dropped silently if busy.
//            R: {8'h00, rx_byte}; clears rx_valid.
//   1 STATUS R: {12'h0, frame_err, overrun, rx_valid, tx_busy}; W: 1 in bit2/bit3 clears it.
//   2 DIV    R/W 16-bit; new value used from next bit-counter reload (no glitch mid-bit).
//   3 --     R: 0; W: ignored.
//  TX FSM IDLE->START->DATA->STOP->IDLE; each state bit lasts DIV+1 cycles;
//   DATA shifts LSB first, 8 bits; txd registered.
//   tx_busy=1 from cycle after DATA write until STOP bit ends; 10-bit frame total.
//  RX: rxd through 2-flop synchronizer. FSM IDLE->START->DATA->STOP->IDLE.
//   IDLE: falling edge of synced rxd -> START, wait (DIV+1)/2 cycles (integer division).
//   START: rxd still 0 -> DATA, else back to IDLE (glitch reject).
//   DATA: sample every DIV+1 cycles, 8 bits LSB first.
//   STOP: sample; 1 -> rx_byte<=shift, rx_valid<=1 (overrun<=1 if rx_valid already 1
//    and not being read); 0 -> frame_err<=1, byte discarded. Then IDLE.
//  Simultaneous events: RX completion same cycle as DATA read -> new byte stored,
//   rx_valid stays 1, no overrun.
//  Simultaneous events: STATUS clear write same cycle as error set -> set wins.
//  DIV: RX requires DIV>=3; smaller values give undefined RX, TX remains correct.
//  Reset mid-frame: txd=1 the cycle after rst, both FSMs IDLE, partial byte lost.
//  Counters are 16-bit; no wrap beyond DIV (reload to 0 at DIV).
// TESTING
//  1 Bus: reads of adr 0004H after reset, issued back-to-back -> ack in each following cycle,
//    dat_o=01B1H (433); stall never 1.
//  2 TX: DIV=3, write DATA=00A5H -> txd 0,1,0,1,0,0,1,0,1,1 each held 4 cycles;
//    tx_busy=1 for 40 cycles; 2nd write while busy ignored.
//  3 RX: DIV=7, drive 8N1 byte 3CH at 8 cycles/bit -> rx_valid=1, irq=1, DATA read=003CH,
//    then STATUS bit1=0.
//  4 Errors: two RX bytes 11H,22H with no read -> STATUS=0006H, DATA=0022H;
//    stop bit 0 -> bit3=1; write STATUS=000CH clears bits 2,3.
//  5 Glitch/reset: 2-cycle low pulse on rxd with DIV=7 -> no rx_valid;
//    rst asserted mid-TX frame -> txd=1 next cycle, tx_busy=0.

Source files
------------

// File: rtl/wb_uart.sv
// wb_uart: Wishbone pipelined slave with an 8N1 UART and a programmable baud divisor.
// The bit period is div+1 clock cycles. Every accepted request gets one registered ack.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   adr           byte address; only adr[2:1] selects a register (DATA/STATUS/DIV/-)
//   dat_i, dat_o  write data and read data (dat_o is non-zero only while acking a read)
//   we, cyc, stb  request qualifiers; a request is cyc & stb
//   ack, stall    registered acknowledge; stall is always 0
//   rxd, txd      serial input (asynchronous, idle high) and serial output (idle high)
//   irq           level interrupt, equal to rx_valid
module wb_uart #(
  parameter int unsigned DEFAULT_DIV = 433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] adr,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  input  logic        we,
  input  logic        cyc,
  input  logic        stb,
  output logic        ack,
  output logic        stall,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Bus decode
  logic       req, wr, rd;
  logic [1:0] idx;
  logic       data_wr, stat_wr, div_wr, data_rd;
  assign req     = cyc & stb;
  assign wr      = req & we;
  assign rd      = req & ~we;
  assign idx     = adr[2:1];
  assign data_wr = wr && (idx == 2'd0);
  assign stat_wr = wr && (idx == 2'd1);
  assign div_wr  = wr && (idx == 2'd2);
  assign data_rd = rd && (idx == 2'd0);

  logic        ack_q, txd_q, tx_busy;
  logic [15:0] dat_q, div_q, rdata;
  logic [7:0]  rx_byte_q;
  logic        rx_valid_q, overrun_q, frame_err_q;

  always_comb begin
    case (idx)
      2'd0:    rdata = {8'h00, rx_byte_q};
      2'd1:    rdata = {12'h000, frame_err_q, overrun_q, rx_valid_q, tx_busy};
      2'd2:    rdata = div_q;
      default: rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      dat_q <= 16'h0000;
      div_q <= 16'(DEFAULT_DIV);
    end else begin
      ack_q <= req;
      dat_q <= rd ? rdata : 16'h0000;
      if (div_wr) div_q <= dat_i;
    end
  end

  // TX: the per-bit divisor is latched at each counter reload so a DIV write never cuts a bit.
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_div_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        tx_tick;
  assign tx_tick = (tx_cnt_q == tx_div_q);

  always_ff @(posedge clk) begin
    if (rst) tx_state_q <= TxIdle;
    else     tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TxIdle:  if (data_wr) tx_state_d = TxStart;
      TxStart: if (tx_tick) tx_state_d = TxData;
      TxData:  if (tx_tick && (tx_bit_q == 3'd7)) tx_state_d = TxStop;
      TxStop:  if (tx_tick) tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txd_q      <= 1'b1;
      tx_cnt_q   <= '0;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else if (tx_state_q == TxIdle) begin
      tx_cnt_q <= '0;
      if (data_wr) begin
        txd_q      <= 1'b0;
        tx_shift_q <= dat_i[7:0];
        tx_div_q   <= div_q;
      end
    end else if (tx_tick) begin
      tx_cnt_q <= '0;
      tx_div_q <= div_q;
      if (tx_state_q == TxStart) begin
        txd_q      <= tx_shift_q[0];
        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
        tx_bit_q   <= '0;
      end else if (tx_state_q == TxData) begin
        tx_bit_q <= tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) begin
          txd_q <= 1'b1;
        end else begin
          txd_q      <= tx_shift_q[0];
          tx_shift_q <= {1'b0, tx_shift_q[7:1]};
        end
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  // RX: two-flop synchronizer plus one more flop for falling-edge detection.
  logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_div_q, rx_half_q, half_m1;
  logic [16:0] div_p1;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_tick, rx_mid, rx_done, rx_bad;

  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign div_p1  = {1'b0, div_q} + 17'd1;
  assign half_m1 = div_p1[16:1] - 16'd1;  // (div+1)/2 cycles, counted from 0
  assign rx_tick = (rx_cnt_q == rx_div_q);
  assign rx_mid  = (rx_cnt_q == rx_half_q);
  assign rx_done = (rx_state_q == RxStop) && rx_tick && rx_s2_q;
  assign rx_bad  = (rx_state_q == RxStop) && rx_tick && !rx_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RxIdle;
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RxIdle:  if (rx_fall) rx_state_d = RxStart;
      RxStart: if (rx_mid) rx_state_d = rx_s2_q ? RxIdle : RxData;  // high again: glitch
      RxData:  if (rx_tick && (rx_bit_q == 3'd7)) rx_state_d = RxStop;
      RxStop:  if (rx_tick) rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q   <= '0;
      rx_div_q   <= '0;
      rx_half_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      unique case (rx_state_q)
        RxIdle: begin
          rx_cnt_q <= '0;
          if (rx_fall) begin
            rx_div_q  <= div_q;
            rx_half_q <= half_m1;
          end
        end
        RxStart: begin
          if (rx_mid) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_div_q <= div_q;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxData: begin
          if (rx_tick) begin
            rx_cnt_q   <= '0;
            rx_div_q   <= div_q;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxStop: rx_cnt_q <= rx_tick ? 16'd0 : rx_cnt_q + 16'd1;
      endcase
    end
  end

  // Status flags: a new event always beats a same-cycle read or clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_done) rx_byte_q <= rx_shift_q;
      if (rx_done)      rx_valid_q <= 1'b1;
      else if (data_rd) rx_valid_q <= 1'b0;
      if (rx_done && rx_valid_q && !data_rd) overrun_q <= 1'b1;
      else if (stat_wr && dat_i[2])          overrun_q <= 1'b0;
      if (rx_bad)                    frame_err_q <= 1'b1;
      else if (stat_wr && dat_i[3]) frame_err_q <= 1'b0;
    end
  end

  // Output process
  always_comb begin
    tx_busy = (tx_state_q != TxIdle);
    irq     = rx_valid_q;
    stall   = 1'b0;
    ack     = ack_q;
    dat_o   = dat_q;
    txd     = txd_q;
  end

  logic unused_bits;
  assign unused_bits = ^{adr[15:3], adr[0], div_p1[0]};

endmodule

// File: tb/tb_wb_uart.sv
// tb_wb_uart: self-checking bench for wb_uart. A vector table covers the bus register map,
// followed by hand-written sequences for TX framing, RX reception, error flags,
// glitch rejection and reset in the middle of a frame.
module tb_wb_uart;
  logic        clk = 1'b0;
  logic        rst, we, cyc, stb, rxd;
  logic [15:0] adr, dat_i;
  logic [15:0] dat_o;
  logic        ack, stall, txd, irq;

  always #5 clk = ~clk;

  wb_uart #(.DEFAULT_DIV(433)) dut (
    .clk   (clk),
    .rst   (rst),
    .adr   (adr),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .we    (we),
    .cyc   (cyc),
    .stb   (stb),
    .ack   (ack),
    .stall (stall),
    .rxd   (rxd),
    .txd   (txd),
    .irq   (irq)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] wdat;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[9];
  logic [15:0] q;
  logic        k;
  logic [9:0]  frame;
  logic        seen_low;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; leaves the request up for one edge and returns the response.
  task automatic bus_op(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rq, output logic rk);
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = w;
    adr   = a;
    dat_i = d;
    @(posedge clk);
    #1;
    rq  = dat_o;
    rk  = ack;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] rq;
    logic        rk;
    bus_op(1'b0, a, 16'h0000, rq, rk);
    chk({nm, "_ack"}, {15'h0, rk}, 16'h0001);
    chk(nm, rq, exp);
  endtask

  task automatic wr(input string nm, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] rq;
    logic        rk;
    bus_op(1'b1, a, d, rq, rk);
    chk({nm, "_ack"}, {15'h0, rk}, 16'h0001);
    chk({nm, "_dat"}, rq, 16'h0000);
  endtask

  // 8 cycles per bit, matching DIV=7.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    cycles(8);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cycles(8);
    end
    rxd = stop_bit;
    cycles(8);
    rxd = 1'b1;
    cycles(6);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; cyc = 1'b0; stb = 1'b0; rxd = 1'b1;
    adr = 16'h0000; dat_i = 16'h0000;
    vecs[0] = '{1'b0, 16'h0004, 16'h0000, 16'h01B1};
    vecs[1] = '{1'b0, 16'h0004, 16'h0000, 16'h01B1};
    vecs[2] = '{1'b0, 16'h0002, 16'h0000, 16'h0000};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 16'h0006, 16'h1234, 16'h0000};
    vecs[5] = '{1'b0, 16'h0006, 16'h0000, 16'h0000};
    vecs[6] = '{1'b1, 16'h0004, 16'h0003, 16'h0000};
    vecs[7] = '{1'b0, 16'h0004, 16'h0000, 16'h0003};
    vecs[8] = '{1'b0, 16'h5004, 16'h0000, 16'h0003};

    cycles(3);
    chk("rst_ack", {15'h0, ack}, 16'h0000);
    chk("rst_dat", dat_o, 16'h0000);
    chk("rst_txd", {15'h0, txd}, 16'h0001);
    chk("rst_irq", {15'h0, irq}, 16'h0000);
    rst = 1'b0;
    cycles(1);

    // Register map, issued back-to-back
    for (int i = 0; i < 9; i++) begin
      bus_op(vecs[i].we, vecs[i].adr, vecs[i].wdat, q, k);
      chk($sformatf("vec%0d_ack", i), {15'h0, k}, 16'h0001);
      chk($sformatf("vec%0d_dat", i), q, vecs[i].exp);
      chk($sformatf("vec%0d_stall", i), {15'h0, stall}, 16'h0000);
    end
    cycles(1);
    chk("idle_ack", {15'h0, ack}, 16'h0000);

    // TX at DIV=3: A5 framed, 4 cycles per bit, with a write while busy at cycle 10
    frame = {1'b1, 8'hA5, 1'b0};
    bus_op(1'b1, 16'h0000, 16'h00A5, q, k);
    chk("tx_wr_ack", {15'h0, k}, 16'h0001);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("txd_c%0d", i), {15'h0, txd}, {15'h0, frame[i/4]});
      if (i == 10) begin
        bus_op(1'b1, 16'h0000, 16'h00FF, q, k);
      end else begin
        bus_op(1'b0, 16'h0002, 16'h0000, q, k);
        chk($sformatf("tx_busy_c%0d", i), q, 16'h0001);
      end
    end
    chk("txd_after_frame", {15'h0, txd}, 16'h0001);
    rd("tx_done_status", 16'h0002, 16'h0000);
    seen_low = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (txd !== 1'b1) seen_low = 1'b1;
      cycles(1);
    end
    chk("tx_busy_write_dropped", {15'h0, seen_low}, 16'h0000);

    // RX at DIV=7
    wr("div7", 16'h0004, 16'h0007);
    send_byte(8'h3C, 1'b1);
    chk("rx_irq", {15'h0, irq}, 16'h0001);
    rd("rx_status", 16'h0002, 16'h0002);
    rd("rx_data", 16'h0000, 16'h003C);
    rd("rx_status_cleared", 16'h0002, 16'h0000);
    chk("rx_irq_cleared", {15'h0, irq}, 16'h0000);

    // Overrun and framing error
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rd("ovr_status", 16'h0002, 16'h0006);
    rd("ovr_data", 16'h0000, 16'h0022);
    rd("ovr_status2", 16'h0002, 16'h0004);
    send_byte(8'h55, 1'b0);
    rd("ferr_status", 16'h0002, 16'h000C);
    wr("clr_status", 16'h0002, 16'h000C);
    rd("clr_status_rd", 16'h0002, 16'h0000);

    // Two-cycle low glitch on rxd must not start a byte
    rxd = 1'b0;
    cycles(2);
    rxd = 1'b1;
    cycles(40);
    rd("glitch_status", 16'h0002, 16'h0000);
    chk("glitch_irq", {15'h0, irq}, 16'h0000);

    // Reset in the middle of a TX frame (DIV=7: bit1 of A5 is 0 during cycles 16..23)
    wr("tx2_wr", 16'h0000, 16'h00A5);
    cycles(19);
    chk("tx2_mid_txd", {15'h0, txd}, 16'h0000);
    rd("tx2_mid_busy", 16'h0002, 16'h0001);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("mid_rst_txd", {15'h0, txd}, 16'h0001);
    chk("mid_rst_ack", {15'h0, ack}, 16'h0000);
    chk("mid_rst_dat", dat_o, 16'h0000);
    rd("mid_rst_status", 16'h0002, 16'h0000);
    rd("mid_rst_div", 16'h0004, 16'h01B1);
    chk("mid_rst_txd_hold", {15'h0, txd}, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
